// File: rtl/drum_pkg.sv
// Shared types and constants for the drum hit conditioner.
// Default timing assumes the 25.175 MHz pixel clock.
package drum_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    HOLD    = 2'd2,
    REFRACT = 2'd3
  } drum_state_e;

  localparam int NUM_CH = 3;
  localparam int HAT    = 0;
  localparam int CYMBAL = 1;
  localparam int TOM    = 2;

  // ~10 ms debounce and ~100 ms (about six frames) visible hold at 25.175 MHz.
  localparam int DEF_DEBOUNCE_CYCLES = 250_000;
  localparam int DEF_HOLD_CYCLES     = 2_500_000;

  // The down-counter only ever holds values up to max(deb,hold)-1.
  function automatic int timer_width(input int deb, input int hold);
    int m;
    int w;
    m = (deb > hold) ? deb : hold;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/drum_channel.sv
// One drum channel: 2-FF synchroniser, debounce/hold/refractory FSM
// sharing a single down-counter, and a saturating hit counter.
module drum_channel
  import drum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_i,
  output logic             hit_o,
  output logic             pulse_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int TW = timer_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
  localparam logic [TW-1:0] DEB_LOAD  = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  drum_state_e      state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync_q, sync_d;
  logic             hit_q, hit_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  always_comb begin
    sync1_d = raw_i;
    sync_d  = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = ARM;
          cnt_d   = DEB_LOAD;
        end
      end
      ARM: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          accept  = 1'b1;
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      HOLD: begin
        // Input deliberately ignored here so retriggers are dropped.
        if (cnt_q == '0) begin
          state_d = REFRACT;
          cnt_d   = DEB_LOAD;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      REFRACT: begin
        if (sync_q) begin
          cnt_d = DEB_LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    hit_d   = (state_d == HOLD);
    pulse_d = accept;
    count_d = (accept && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      hit_q   <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync_q  <= sync_d;
      hit_q   <= hit_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  assign hit_o   = hit_q;
  assign pulse_o = pulse_q;
  assign count_o = count_q;

endmodule

// File: rtl/drum_hit_conditioner.sv
// Three independent drum channels feeding the VGA pattern generator's
// hat/cymbal/tom hit inputs on the pixel clock.
module drum_hit_conditioner
  import drum_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hat_raw_i,
  input  logic             cymbal_raw_i,
  input  logic             tom_raw_i,
  output logic             hat_hit_o,
  output logic             cymbal_hit_o,
  output logic             tom_hit_o,
  output logic [2:0]       hit_pulse_o,
  output logic [CNT_W-1:0] hat_count_o,
  output logic [CNT_W-1:0] cymbal_count_o,
  output logic [CNT_W-1:0] tom_count_o
);

  logic [NUM_CH-1:0]            raw;
  logic [NUM_CH-1:0]            hit;
  logic [NUM_CH-1:0][CNT_W-1:0] count;

  assign raw[HAT]    = hat_raw_i;
  assign raw[CYMBAL] = cymbal_raw_i;
  assign raw[TOM]    = tom_raw_i;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    drum_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw[ch]),
      .hit_o  (hit[ch]),
      .pulse_o(hit_pulse_o[ch]),
      .count_o(count[ch])
    );
  end

  assign hat_hit_o      = hit[HAT];
  assign cymbal_hit_o   = hit[CYMBAL];
  assign tom_hit_o      = hit[TOM];
  assign hat_count_o    = count[HAT];
  assign cymbal_count_o = count[CYMBAL];
  assign tom_count_o    = count[TOM];

endmodule
